// File: rtl/misaligned_access_unit.sv
// rtl/misaligned_access_unit.sv - splits misaligned loads/stores into byte accesses and reassembles load data
module misaligned_access_unit #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_write_i,
    input  logic [1:0]            req_size_i,
    input  logic                  req_unsigned_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic [1:0]            mem_size_o,
    output logic                  mem_read_o,
    output logic                  mem_write_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  resp_valid_o,
    output logic [DATA_WIDTH-1:0] resp_rdata_o,
    output logic                  resp_err_o
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                state_q, state_nx;
    logic                  write_q, unsigned_q, split_q, err_q;
    logic [1:0]            size_q, k_q, k_last_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q, asm_q, ext_data;
    logic                  accept, misaligned;
    logic [1:0]            k_last_nx;

    assign accept = req_valid_i & req_ready_o;

    always_comb begin
        misaligned = 1'b0;
        k_last_nx  = 2'd0;
        case (req_size_i)
            2'b01: misaligned = req_addr_i[0];
            2'b10: misaligned = |req_addr_i[1:0];
            default: misaligned = 1'b0;
        endcase
        if (misaligned) begin
            k_last_nx = (req_size_i == 2'b01) ? 2'd1 : 2'd3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nx;
        end
    end

    always_comb begin
        state_nx = state_q;
        case (state_q)
            IDLE:    if (accept) state_nx = (req_size_i == 2'b11) ? RESP : ACCESS;
            ACCESS:  if (k_q == k_last_q) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_q    <= 1'b0;
            unsigned_q <= 1'b0;
            split_q    <= 1'b0;
            err_q      <= 1'b0;
            size_q     <= 2'd0;
            k_q        <= 2'd0;
            k_last_q   <= 2'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            asm_q      <= '0;
        end else if (accept) begin
            write_q    <= req_write_i;
            unsigned_q <= req_unsigned_i;
            split_q    <= misaligned;
            err_q      <= (req_size_i == 2'b11);
            size_q     <= req_size_i;
            k_q        <= 2'd0;
            k_last_q   <= k_last_nx;
            addr_q     <= req_addr_i;
            wdata_q    <= req_wdata_i;
            asm_q      <= '0;
        end else if (state_q == ACCESS) begin
            k_q <= k_q + 2'd1;
            if (!write_q) begin
                if (split_q) begin
                    asm_q[8*k_q +: 8] <= mem_rdata_i[7:0];
                end else begin
                    asm_q <= mem_rdata_i;
                end
            end
        end
    end

    // Memory-side extension is discarded; we re-extend from our own size/unsigned bits.
    always_comb begin
        case (size_q)
            2'b00:   ext_data = {{(DATA_WIDTH-8){~unsigned_q & asm_q[7]}}, asm_q[7:0]};
            2'b01:   ext_data = {{(DATA_WIDTH-16){~unsigned_q & asm_q[15]}}, asm_q[15:0]};
            default: ext_data = asm_q;
        endcase
    end

    always_comb begin
        req_ready_o  = (state_q == IDLE) & rst_n;
        mem_addr_o   = '0;
        mem_wdata_o  = '0;
        mem_size_o   = 2'b00;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        resp_valid_o = 1'b0;
        resp_rdata_o = '0;
        resp_err_o   = 1'b0;
        case (state_q)
            ACCESS: begin
                mem_addr_o  = split_q ? addr_q + ADDR_WIDTH'(k_q) : addr_q;
                mem_size_o  = split_q ? 2'b00 : size_q;
                mem_read_o  = ~write_q;
                mem_write_o = write_q;
                if (write_q) begin
                    mem_wdata_o = split_q ? {{(DATA_WIDTH-8){1'b0}}, wdata_q[8*k_q +: 8]} : wdata_q;
                end
            end
            RESP: begin
                resp_valid_o = 1'b1;
                resp_err_o   = err_q;
                resp_rdata_o = (!write_q && !err_q) ? ext_data : '0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_misaligned_access_unit.sv
// tb/tb_misaligned_access_unit.sv - directed table-driven bench for misaligned_access_unit
module tb_misaligned_access_unit;

    logic        clk, rst_n;
    logic        req_valid_i, req_ready_o, req_write_i, req_unsigned_i;
    logic [1:0]  req_size_i;
    logic [7:0]  req_addr_i;
    logic [31:0] req_wdata_i;
    logic [7:0]  mem_addr_o;
    logic [31:0] mem_wdata_o, mem_rdata_i;
    logic [1:0]  mem_size_o;
    logic        mem_read_o, mem_write_o;
    logic        resp_valid_o, resp_err_o;
    logic [31:0] resp_rdata_o;

    misaligned_access_unit #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_write_i(req_write_i), .req_size_i(req_size_i),
        .req_unsigned_i(req_unsigned_i), .req_addr_i(req_addr_i),
        .req_wdata_i(req_wdata_i),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_size_o(mem_size_o), .mem_read_o(mem_read_o),
        .mem_write_o(mem_write_o), .mem_rdata_i(mem_rdata_i),
        .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o),
        .resp_err_o(resp_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte-addressed memory that sign-extends its own read data.
    logic [7:0]  mem [256];
    logic        mem_clear;
    logic [7:0]  a1, a2, a3;
    logic [31:0] log_addr[$], log_data[$];
    logic [1:0]  log_size[$];
    logic        log_wr[$];

    assign a1 = mem_addr_o + 8'd1;
    assign a2 = mem_addr_o + 8'd2;
    assign a3 = mem_addr_o + 8'd3;

    always_comb begin
        case (mem_size_o)
            2'b00:   mem_rdata_i = {{24{mem[mem_addr_o][7]}}, mem[mem_addr_o]};
            2'b01:   mem_rdata_i = {{16{mem[a1][7]}}, mem[a1], mem[mem_addr_o]};
            default: mem_rdata_i = {mem[a3], mem[a2], mem[a1], mem[mem_addr_o]};
        endcase
    end

    always @(negedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        end else if (mem_read_o || mem_write_o) begin
            log_addr.push_back({24'h0, mem_addr_o});
            log_data.push_back(mem_wdata_o);
            log_size.push_back(mem_size_o);
            log_wr.push_back(mem_write_o);
            if (mem_write_o) begin
                mem[mem_addr_o] = mem_wdata_o[7:0];
                if (mem_size_o != 2'b00) mem[a1] = mem_wdata_o[15:8];
                if (mem_size_o == 2'b10) begin
                    mem[a2] = mem_wdata_o[23:16];
                    mem[a3] = mem_wdata_o[31:24];
                end
            end
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic clear_mem();
        mem_clear = 1'b1;
        @(negedge clk);
        #1 mem_clear = 1'b0;
    endtask

    // Latency counts the request cycle through the response cycle.
    task automatic do_req(input logic w, input logic [1:0] sz, input logic uns,
                          input logic [7:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rd, output logic er,
                          output int lat, output int start);
        int g = 0;
        while (!req_ready_o && g < 20) begin
            @(posedge clk); #1; g++;
        end
        chk("ready_before_req", {31'b0, req_ready_o}, 32'd1);
        start          = log_addr.size();
        req_write_i    = w;
        req_size_i     = sz;
        req_unsigned_i = uns;
        req_addr_i     = addr;
        req_wdata_i    = wdata;
        req_valid_i    = 1'b1;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        lat = 1;
        while (!resp_valid_o && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        rd = resp_rdata_o;
        er = resp_err_o;
        @(posedge clk); #1;
        chk("resp_drop", {31'b0, resp_valid_o}, 32'd0);
        chk("ready_back", {31'b0, req_ready_o}, 32'd1);
    endtask

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        uns;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
        int          exp_n;
        logic [1:0]  exp_msz;
    } vec_t;

    vec_t vecs[17];

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat, st;
        logic [31:0] exp_addr[4];
        logic [31:0] exp_data[4];

        rst_n = 1'b0; req_valid_i = 1'b0; req_write_i = 1'b0; req_size_i = 2'b00;
        req_unsigned_i = 1'b0; req_addr_i = 8'h00; req_wdata_i = 32'h0; mem_clear = 1'b0;
        clear_mem();
        #2;
        chk("rst_ready", {31'b0, req_ready_o}, 32'd0);
        chk("rst_mem_rw", {30'b0, mem_read_o, mem_write_o}, 32'd0);
        chk("rst_resp", {31'b0, resp_valid_o}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        #1 chk("post_rst_ready", {31'b0, req_ready_o}, 32'd1);

        // Misaligned word store into zeroed memory.
        do_req(1'b1, 2'b10, 1'b0, 8'h05, 32'h11223344, rd, er, lat, st);
        chk("mis_st_lat", lat, 5);
        chk("mis_st_n", log_addr.size() - st, 4);
        exp_addr = '{32'h05, 32'h06, 32'h07, 32'h08};
        exp_data = '{32'h44, 32'h33, 32'h22, 32'h11};
        for (int i = 0; i < 4 && st + i < log_addr.size(); i++) begin
            chk("mis_st_addr", log_addr[st+i], exp_addr[i]);
            chk("mis_st_data", log_data[st+i], exp_data[i]);
            chk("mis_st_size", {30'b0, log_size[st+i]}, 32'd0);
        end

        vecs[0]  = '{1'b1, 2'b10, 1'b0, 8'h10, 32'hDEADBEEF, 32'h0,        1'b0, 2, 1, 2'b10};
        vecs[1]  = '{1'b0, 2'b10, 1'b0, 8'h10, 32'h0,        32'hDEADBEEF, 1'b0, 2, 1, 2'b10};
        vecs[2]  = '{1'b0, 2'b10, 1'b0, 8'h04, 32'h0,        32'h22334400, 1'b0, 2, 1, 2'b10};
        vecs[3]  = '{1'b0, 2'b10, 1'b0, 8'h05, 32'h0,        32'h11223344, 1'b0, 5, 4, 2'b00};
        vecs[4]  = '{1'b1, 2'b00, 1'b0, 8'h03, 32'hCAFE0080, 32'h0,        1'b0, 2, 1, 2'b00};
        vecs[5]  = '{1'b1, 2'b00, 1'b0, 8'h04, 32'h000000FF, 32'h0,        1'b0, 2, 1, 2'b00};
        vecs[6]  = '{1'b0, 2'b01, 1'b0, 8'h03, 32'h0,        32'hFFFFFF80, 1'b0, 3, 2, 2'b00};
        vecs[7]  = '{1'b0, 2'b01, 1'b1, 8'h03, 32'h0,        32'h0000FF80, 1'b0, 3, 2, 2'b00};
        vecs[8]  = '{1'b0, 2'b00, 1'b0, 8'h10, 32'h0,        32'hFFFFFFEF, 1'b0, 2, 1, 2'b00};
        vecs[9]  = '{1'b0, 2'b00, 1'b1, 8'h11, 32'h0,        32'h000000BE, 1'b0, 2, 1, 2'b00};
        vecs[10] = '{1'b0, 2'b01, 1'b0, 8'h12, 32'h0,        32'hFFFFDEAD, 1'b0, 2, 1, 2'b01};
        vecs[11] = '{1'b1, 2'b01, 1'b0, 8'h21, 32'h00001234, 32'h0,        1'b0, 3, 2, 2'b00};
        vecs[12] = '{1'b0, 2'b01, 1'b0, 8'h21, 32'h0,        32'h00001234, 1'b0, 3, 2, 2'b00};
        vecs[13] = '{1'b0, 2'b11, 1'b0, 8'h20, 32'h0,        32'h0,        1'b1, 1, 0, 2'b00};
        vecs[14] = '{1'b1, 2'b11, 1'b0, 8'h20, 32'hFFFFFFFF, 32'h0,        1'b1, 1, 0, 2'b00};
        vecs[15] = '{1'b0, 2'b10, 1'b0, 8'h20, 32'h0,        32'h00123400, 1'b0, 2, 1, 2'b10};
        vecs[16] = '{1'b0, 2'b01, 1'b1, 8'h10, 32'h0,        32'h0000BEEF, 1'b0, 2, 1, 2'b01};

        for (int i = 0; i < 17; i++) begin
            do_req(vecs[i].w, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wdata, rd, er, lat, st);
            chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
            chk($sformatf("v%0d_err", i), {31'b0, er}, {31'b0, vecs[i].exp_err});
            chk($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
            chk($sformatf("v%0d_naccess", i), log_addr.size() - st, vecs[i].exp_n);
            if (vecs[i].exp_n > 0 && log_addr.size() > st)
                chk($sformatf("v%0d_msize", i), {30'b0, log_size[log_addr.size()-1]}, {30'b0, vecs[i].exp_msz});
        end

        // Split store wrapping past the top of the address space.
        do_req(1'b1, 2'b10, 1'b0, 8'hFE, 32'hAABBCCDD, rd, er, lat, st);
        chk("wrap_n", log_addr.size() - st, 4);
        exp_addr = '{32'hFE, 32'hFF, 32'h00, 32'h01};
        exp_data = '{32'hDD, 32'hCC, 32'hBB, 32'hAA};
        for (int i = 0; i < 4 && st + i < log_addr.size(); i++) begin
            chk("wrap_addr", log_addr[st+i], exp_addr[i]);
            chk("wrap_data", log_data[st+i], exp_data[i]);
            chk("wrap_is_write", {31'b0, log_wr[st+i]}, 32'd1);
        end
        do_req(1'b0, 2'b10, 1'b0, 8'hFE, 32'h0, rd, er, lat, st);
        chk("wrap_load", rd, 32'hAABBCCDD);

        // Reset during the third byte of a split store.
        clear_mem();
        @(posedge clk); #1;
        req_write_i = 1'b1; req_size_i = 2'b10; req_unsigned_i = 1'b0;
        req_addr_i = 8'h05; req_wdata_i = 32'h11223344; req_valid_i = 1'b1;
        @(posedge clk); #1 req_valid_i = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_mid_pre_write", {31'b0, mem_write_o}, 32'd1);
        chk("rst_mid_pre_addr", {24'b0, mem_addr_o}, 32'h07);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_write_drop", {31'b0, mem_write_o}, 32'd0);
        chk("rst_mid_addr_zero", {24'b0, mem_addr_o}, 32'h0);
        chk("rst_mid_ready_low", {31'b0, req_ready_o}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        #1 chk("rst_mid_ready", {31'b0, req_ready_o}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("rst_mid_no_resp", {31'b0, resp_valid_o}, 32'd0);
        end
        chk("rst_mid_m05", {24'b0, mem[8'h05]}, 32'h44);
        chk("rst_mid_m06", {24'b0, mem[8'h06]}, 32'h33);
        chk("rst_mid_m07", {24'b0, mem[8'h07]}, 32'h00);
        chk("rst_mid_m08", {24'b0, mem[8'h08]}, 32'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
